// File: rtl/mcpu_pkg.sv
// Shared encodings for the micro-CPU ALU sequencer: instruction classes,
// ALU opcodes, FSM states and instruction field layout helpers.
package mcpu_pkg;

  localparam int CLS_W = 2;
  localparam int OP_W  = 2;

  localparam logic [1:0] CLS_ALU   = 2'd0;
  localparam logic [1:0] CLS_LOADI = 2'd1;
  localparam logic [1:0] CLS_NOP   = 2'd2;
  localparam logic [1:0] CLS_HALT  = 2'd3;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_ADD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OPERAND = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_HALTED  = 3'd4
  } state_e;

  // Instruction layout, MSB first: {class, aluop, rd, rs1, rs2}
  function automatic int f_instr_w(input int ra);
    return CLS_W + OP_W + 3 * ra;
  endfunction

  function automatic int f_cls_lsb(input int ra);
    return OP_W + 3 * ra;
  endfunction

  function automatic int f_op_lsb(input int ra);
    return 3 * ra;
  endfunction

  function automatic int f_rd_lsb(input int ra);
    return 2 * ra;
  endfunction

  function automatic int f_rs1_lsb(input int ra);
    return ra;
  endfunction

  function automatic int f_rs2_lsb(input int ra);
    return 0;
  endfunction

endpackage

// File: rtl/mcpu_regfile.sv
// Small register file: two combinational read ports, one debug read port,
// one synchronous write port, synchronous reset to zero.
module mcpu_regfile #(
  parameter int WORD_SIZE     = 2,
  parameter int REG_ADDR_SIZE = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     we,
  input  logic [REG_ADDR_SIZE-1:0] waddr,
  input  logic [WORD_SIZE-1:0]     wdata,
  input  logic [REG_ADDR_SIZE-1:0] raddr1,
  output logic [WORD_SIZE-1:0]     rdata1,
  input  logic [REG_ADDR_SIZE-1:0] raddr2,
  output logic [WORD_SIZE-1:0]     rdata2,
  input  logic [REG_ADDR_SIZE-1:0] dbg_addr,
  output logic [WORD_SIZE-1:0]     dbg_data
);

  localparam int NWORDS = 2 ** REG_ADDR_SIZE;

  logic [WORD_SIZE-1:0] mem_q [NWORDS];
  logic [WORD_SIZE-1:0] mem_d [NWORDS];

  // Next contents: hold, or replace the addressed word on a write
  always_comb begin
    for (int i = 0; i < NWORDS; i++) mem_d[i] = mem_q[i];
    if (we) mem_d[waddr] = wdata;
  end

  // Storage update; reset clears every word
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NWORDS; i++) begin
      if (RESET) mem_q[i] <= '0;
      else       mem_q[i] <= mem_d[i];
    end
  end

  assign rdata1   = mem_q[raddr1];
  assign rdata2   = mem_q[raddr2];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/mcpu_alu_sequencer.sv
// Multi-cycle controller for the shared combinational ALU. Takes one
// instruction per valid/ready handshake, reads operands into registered ALU
// inputs, and writes the ALU result (or an immediate) back to the regfile.
module mcpu_alu_sequencer
  import mcpu_pkg::*;
#(
  parameter int CMD_SIZE      = 2,
  parameter int WORD_SIZE     = 2,
  parameter int REG_ADDR_SIZE = 2
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          instr_valid,
  output logic                          instr_ready,
  input  logic [4+3*REG_ADDR_SIZE-1:0]  instr,
  input  logic [WORD_SIZE-1:0]          instr_imm,
  output logic [CMD_SIZE-1:0]           alu_opcode,
  output logic [WORD_SIZE-1:0]          alu_r1,
  output logic [WORD_SIZE-1:0]          alu_r2,
  input  logic [WORD_SIZE-1:0]          alu_out,
  input  logic                          alu_overflow,
  output logic                          done,
  output logic [WORD_SIZE-1:0]          result,
  output logic                          overflow_flag,
  output logic                          halted,
  input  logic [REG_ADDR_SIZE-1:0]      dbg_addr,
  output logic [WORD_SIZE-1:0]          dbg_data
);

  localparam int RA      = REG_ADDR_SIZE;
  localparam int CLS_LSB = f_cls_lsb(RA);
  localparam int OP_LSB  = f_op_lsb(RA);
  localparam int RD_LSB  = f_rd_lsb(RA);
  localparam int RS1_LSB = f_rs1_lsb(RA);
  localparam int RS2_LSB = f_rs2_lsb(RA);

  state_e state_q, state_d;

  logic [1:0]           cls_q,  cls_d;
  logic [CMD_SIZE-1:0]  op_q,   op_d;
  logic [RA-1:0]        rd_q,   rd_d;
  logic [RA-1:0]        rs1_q,  rs1_d;
  logic [RA-1:0]        rs2_q,  rs2_d;
  logic [WORD_SIZE-1:0] imm_q,  imm_d;
  logic [CMD_SIZE-1:0]  alu_opcode_q, alu_opcode_d;
  logic [WORD_SIZE-1:0] alu_r1_q, alu_r1_d;
  logic [WORD_SIZE-1:0] alu_r2_q, alu_r2_d;
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;
  logic                 halted_q, halted_d;

  logic                 hs;
  logic                 rf_we;
  logic [RA-1:0]        rf_waddr;
  logic [WORD_SIZE-1:0] rf_wdata;
  logic [WORD_SIZE-1:0] rf_rd1, rf_rd2;

  logic [1:0]           f_cls;
  logic [CMD_SIZE-1:0]  f_op;
  logic [RA-1:0]        f_rd, f_rs1, f_rs2;

  assign f_cls = instr[CLS_LSB +: 2];
  assign f_op  = instr[OP_LSB  +: CMD_SIZE];
  assign f_rd  = instr[RD_LSB  +: RA];
  assign f_rs1 = instr[RS1_LSB +: RA];
  assign f_rs2 = instr[RS2_LSB +: RA];

  assign hs = instr_valid && instr_ready;

  mcpu_regfile #(
    .WORD_SIZE     (WORD_SIZE),
    .REG_ADDR_SIZE (REG_ADDR_SIZE)
  ) u_regfile (
    .CLK      (CLK),
    .RESET    (RESET),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .raddr1   (rs1_q),
    .rdata1   (rf_rd1),
    .raddr2   (rs2_q),
    .rdata2   (rf_rd2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // FSM state register; reset abandons any in-flight instruction
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: ALU ops take OPERAND+EXECUTE, everything else one WRITE cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (hs) state_d = (f_cls == CLS_ALU) ? ST_OPERAND : ST_WRITE;
      ST_OPERAND: state_d = ST_EXECUTE;
      ST_EXECUTE: state_d = ST_IDLE;
      ST_WRITE:   state_d = (cls_q == CLS_HALT) ? ST_HALTED : ST_IDLE;
      ST_HALTED:  state_d = ST_HALTED;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath next values per state
  always_comb begin
    instr_ready  = (state_q == ST_IDLE) && !RESET;
    cls_d        = cls_q;
    op_d         = op_q;
    rd_d         = rd_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    imm_d        = imm_q;
    alu_opcode_d = alu_opcode_q;
    alu_r1_d     = alu_r1_q;
    alu_r2_d     = alu_r2_q;
    result_d     = result_q;
    ovf_d        = ovf_q;
    done_d       = 1'b0;
    halted_d     = halted_q;
    rf_we        = 1'b0;
    rf_waddr     = rd_q;
    rf_wdata     = alu_out;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          cls_d = f_cls;
          op_d  = f_op;
          rd_d  = f_rd;
          rs1_d = f_rs1;
          rs2_d = f_rs2;
          imm_d = instr_imm;
        end
      end
      ST_OPERAND: begin
        // Operands read before any writeback, so rd==rs sees the old value
        alu_r1_d     = rf_rd1;
        alu_r2_d     = rf_rd2;
        alu_opcode_d = op_q;
      end
      ST_EXECUTE: begin
        rf_we    = 1'b1;
        rf_wdata = alu_out;
        result_d = alu_out;
        ovf_d    = (op_q == CMD_SIZE'(OP_ADD)) ? alu_overflow : 1'b0;
        done_d   = 1'b1;
      end
      ST_WRITE: begin
        done_d = 1'b1;
        if (cls_q == CLS_LOADI) begin
          rf_we    = 1'b1;
          rf_wdata = imm_q;
          result_d = imm_q;
        end
        if (cls_q == CLS_HALT) halted_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cls_q        <= '0;
      op_q         <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      imm_q        <= '0;
      alu_opcode_q <= '0;
      alu_r1_q     <= '0;
      alu_r2_q     <= '0;
      result_q     <= '0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      cls_q        <= cls_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      imm_q        <= imm_d;
      alu_opcode_q <= alu_opcode_d;
      alu_r1_q     <= alu_r1_d;
      alu_r2_q     <= alu_r2_d;
      result_q     <= result_d;
      ovf_q        <= ovf_d;
      done_q       <= done_d;
      halted_q     <= halted_d;
    end
  end

  assign alu_opcode    = alu_opcode_q;
  assign alu_r1        = alu_r1_q;
  assign alu_r2        = alu_r2_q;
  assign result        = result_q;
  assign overflow_flag = ovf_q;
  assign done          = done_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_mcpu_alu_sequencer.sv
// Scoreboard bench for mcpu_alu_sequencer wired to a behavioural 4-function ALU.
module tb_mcpu_alu_sequencer;

  localparam int CS = 2;
  localparam int WS = 2;
  localparam int RA = 2;
  localparam int IW = 4 + 3 * RA;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr;
  logic [WS-1:0] instr_imm;
  logic [CS-1:0] alu_opcode;
  logic [WS-1:0] alu_r1, alu_r2, alu_out;
  logic          alu_overflow;
  logic          done;
  logic [WS-1:0] result;
  logic          overflow_flag;
  logic          halted;
  logic [RA-1:0] dbg_addr;
  logic [WS-1:0] dbg_data;

  always #5 CLK = ~CLK;

  mcpu_alu_sequencer #(.CMD_SIZE(CS), .WORD_SIZE(WS), .REG_ADDR_SIZE(RA)) dut (
    .CLK(CLK), .RESET(RESET), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_imm(instr_imm), .alu_opcode(alu_opcode), .alu_r1(alu_r1),
    .alu_r2(alu_r2), .alu_out(alu_out), .alu_overflow(alu_overflow), .done(done),
    .result(result), .overflow_flag(overflow_flag), .halted(halted),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Reference ALU: AND/OR/XOR/ADD, OVERFLOW = ADD carry-out
  logic [WS:0] sum;
  assign sum = {1'b0, alu_r1} + {1'b0, alu_r2};
  assign alu_out = (alu_opcode == 2'd0) ? (alu_r1 & alu_r2) :
                   (alu_opcode == 2'd1) ? (alu_r1 | alu_r2) :
                   (alu_opcode == 2'd2) ? (alu_r1 ^ alu_r2) : sum[WS-1:0];
  assign alu_overflow = (alu_opcode == 2'd3) & sum[WS];

  typedef struct {
    logic [WS-1:0] res;
    logic          ovf;
    int            lat;
    int            hs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("overflow_flag", overflow_flag, e.ovf);
        chk("latency", cyc - e.hs, e.lat);
      end
    end
  end

  function automatic logic [IW-1:0] mk(input logic [1:0] c, input logic [1:0] op,
                                       input logic [1:0] rd, input logic [1:0] r1,
                                       input logic [1:0] r2);
    return {c, op, rd, r1, r2};
  endfunction

  // Drive an instruction at a negedge and hold valid until the handshake edge
  task automatic issue(input logic [IW-1:0] ins, input logic [WS-1:0] imm,
                       input logic [WS-1:0] eres, input logic eovf, input int lat,
                       input bit expect_done);
    int budget;
    exp_t e;
    @(negedge CLK);
    instr = ins;
    instr_imm = imm;
    instr_valid = 1'b1;
    budget = 20;
    while (!instr_ready && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    if (!instr_ready) begin
      chk("handshake_timeout", 0, 1);
    end else begin
      if (expect_done) begin
        e.res = eres; e.ovf = eovf; e.lat = lat; e.hs = cyc + 1;
        sb.push_back(e);
      end
      @(posedge CLK);
    end
  endtask

  task automatic idle(input int n);
    @(negedge CLK);
    instr_valid = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic rchk(input string nm, input logic [RA-1:0] a, input logic [WS-1:0] exp);
    dbg_addr = a;
    #1;
    chk(nm, dbg_data, exp);
  endtask

  initial begin
    int snap;
    int budget;
    RESET = 1'b1; instr_valid = 1'b0; instr = '0; instr_imm = '0; dbg_addr = '0;
    repeat (3) @(negedge CLK);
    // Reset state
    chk("rst_ready", instr_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_halted", halted, 0);
    chk("rst_result", result, 0);
    chk("rst_ovf", overflow_flag, 0);
    chk("rst_alu", {alu_opcode, alu_r1, alu_r2}, 0);
    for (int i = 0; i < 4; i++) rchk("rst_reg", 2'(i), 0);
    RESET = 1'b0;
    #1;
    chk("ready_after_reset", instr_ready, 1);

    // LOADI r0=3, r1=2
    issue(mk(2'd1, 2'd0, 2'd0, 2'd0, 2'd0), 2'd3, 2'd3, 1'b0, 1, 1);
    issue(mk(2'd1, 2'd0, 2'd1, 2'd0, 2'd0), 2'd2, 2'd2, 1'b0, 1, 1);
    idle(2);
    rchk("r0_loadi", 2'd0, 2'd3);
    rchk("r1_loadi", 2'd1, 2'd2);
    chk("ovf_after_loadi", overflow_flag, 0);

    // ADD r2=3+2 wraps to 1 with carry; LOADI keeps overflow; AND clears it
    issue(mk(2'd0, 2'd3, 2'd2, 2'd0, 2'd1), 2'd0, 2'd1, 1'b1, 2, 1);
    issue(mk(2'd1, 2'd0, 2'd3, 2'd0, 2'd0), 2'd0, 2'd0, 1'b1, 1, 1);
    issue(mk(2'd0, 2'd0, 2'd3, 2'd0, 2'd1), 2'd0, 2'd2, 1'b0, 2, 1);
    idle(3);
    rchk("r2_add", 2'd2, 2'd1);
    rchk("r3_and", 2'd3, 2'd2);

    // OR r0=r0|r1 then XOR r1=r0^r1 back-to-back, valid held high
    snap = done_cnt;
    issue(mk(2'd0, 2'd1, 2'd0, 2'd0, 2'd1), 2'd0, 2'd3, 1'b0, 2, 1);
    @(negedge CLK);
    chk("ready_operand", instr_ready, 0);
    @(negedge CLK);
    chk("ready_execute", instr_ready, 0);
    issue(mk(2'd0, 2'd2, 2'd1, 2'd0, 2'd1), 2'd0, 2'd1, 1'b0, 2, 1);
    idle(3);
    rchk("r0_or", 2'd0, 2'd3);
    rchk("r1_xor", 2'd1, 2'd1);
    chk("two_done_pulses", done_cnt - snap, 2);

    // ADD in flight, reset on the writeback edge
    snap = done_cnt;
    issue(mk(2'd0, 2'd3, 2'd2, 2'd0, 2'd1), 2'd0, 2'd0, 1'b0, 2, 0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 4; i++) rchk("abort_reg", 2'(i), 0);
    chk("abort_result", result, 0);
    chk("abort_done", done, 0);
    chk("abort_ovf", overflow_flag, 0);
    chk("abort_alu", {alu_opcode, alu_r1, alu_r2}, 0);
    instr_valid = 1'b0;
    RESET = 1'b0;
    #1;
    chk("abort_ready", instr_ready, 1);
    chk("abort_no_done", done_cnt - snap, 0);

    // LOADI r0=2, then NOP and HALT with valid held
    issue(mk(2'd1, 2'd0, 2'd0, 2'd0, 2'd0), 2'd2, 2'd2, 1'b0, 1, 1);
    issue(mk(2'd2, 2'd0, 2'd0, 2'd0, 2'd0), 2'd0, 2'd2, 1'b0, 1, 1);
    issue(mk(2'd3, 2'd0, 2'd0, 2'd0, 2'd0), 2'd0, 2'd2, 1'b0, 1, 1);
    @(negedge CLK);
    instr = mk(2'd1, 2'd0, 2'd1, 2'd0, 2'd0);
    instr_imm = 2'd3;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      chk("halted_ready", instr_ready, 0);
      chk("halted_flag", halted, 1);
    end
    rchk("halted_r1_untouched", 2'd1, 2'd0);
    rchk("halted_r0_kept", 2'd0, 2'd2);
    RESET = 1'b1;
    @(negedge CLK);
    chk("halt_cleared", halted, 0);
    instr_valid = 1'b0;
    RESET = 1'b0;
    #1;
    chk("ready_after_halt_reset", instr_ready, 1);

    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
